free_list: RTL
==============

Name: free_list

Overview:
- Circular buffer of free physical register tags for the 3-wide R10K-style rename stage.
- Supplies new PRs to the map table at dispatch and reclaims Told tags at retire.
- Rebuilds its free set on branch recovery (BPRecoverEN), in step with the map table's restore from the architectural map table.
- Lane 2 is the oldest instruction in a dispatch/retire bundle; lane 0 is the youngest.

Parameters:
PR_NUM, 64, total physical registers
PR_W, 6, physical tag width, equals `PR
AR_NUM, 32, architectural registers; PRs 0..AR_NUM-1 are architecturally mapped at reset
FL_SIZE, PR_NUM-AR_NUM (32), buffer depth

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
dispatch_req  input  3  lane i needs a new PR (dest AR != 0)
free_pr_out  output  3xPR_W  PR offered to lane i
free_pr_valid  output  3  lane i is granted free_pr_out[i] this cycle
free_num  output  2  min(count,3); dispatch must not request more than this
retire_en  input  3  lane i retires a dest-writing instruction
retire_told  input  3xPR_W  Told freed by lane i
BPRecoverEN  input  1  mispredict recovery

Behaviour:
- State:
  - entries[FL_SIZE] of PR_W bits
  - head and tail pointers, log2(FL_SIZE) bits, wrap modulo FL_SIZE
  - count register, 0..FL_SIZE; head==tail is ambiguous, so count is required.
- Reset (synchronous, active-high):
  - entries[i]=AR_NUM+i, head=0, tail=0, count=FL_SIZE.
  - Outputs the next cycle: free_num=3, free_pr_out={32,33,34} for lanes 2,1,0 if all requesting.
- Allocation (combinational read, commit at posedge):
  - Requesting lanes take consecutive entries from head in order lane 2, 1, 0; non-requesting lanes are skipped.
  - Example: req=3'b101 gives lane2=entries[head], lane0=entries[head+1].
  - free_pr_valid[i]=dispatch_req[i] && (rank of lane i among requesters) < count.
  - Non-requesting lanes: free_pr_valid=0; free_pr_out is don't-care but deterministic (the entry at that lane's rank).
  - head += number granted; count -= granted.
  - Zero latency: a PR appears on free_pr_out the same cycle it is requested.
- Free:
  - Retiring lanes write retire_told to entries[tail], entries[tail+1], ... in order lane 2, 1, 0.
  - tail += number retiring; count += number retiring.
- Same-cycle alloc and free:
  - free_num and grants use the current count only; no bypass of same-cycle frees.
  - count_next = count - granted + freed.
- Wrap-around: all pointer arithmetic is modulo FL_SIZE. Allocation straddling index FL_SIZE-1 to 0 returns the correct entries.
- Empty (count=0): free_num=0, all free_pr_valid=0, head unchanged.
- Full (count=FL_SIZE): a retire that would exceed FL_SIZE is a protocol violation. The push is dropped and the counter saturates at FL_SIZE.
- BPRecoverEN=1 at posedge:
  - This cycle's retires are applied first.
  - Then head := new tail and count := FL_SIZE.
  - Dispatch grants are suppressed: free_pr_valid=0 and no head advance.
  - Correctness invariant: entries between tail and head still hold the squashed in-flight PRs, which become free again.
- Reset has priority over BPRecoverEN, which has priority over dispatch.

Optional Feature:
- FREELIST_DEBUG_EN defined:
  - Adds outputs free_list_disp [FL_SIZE x PR_W], head_disp, tail_disp, count_disp for the bench display tasks.
  - Adds a simulation check that $error()s on retire overflow and on grants exceeding count.
- Undefined: none of these ports or checks exist; the core function is identical.

Test Plan:
- Reset released; dispatch_req=3'b111 -> free_pr_out {32,33,34}, valid 3'b111; next cycle free_num=3, count=29.
- Cycle 1: req=3'b110 -> lane2=35, lane1=36, lane0 not valid. Cycle 2: req=3'b001 -> lane0=37, count=26.
- Drain to count=2 with req=3'b111 -> valid=3'b110 and free_num=2; next cycle free_num=0, all valid=0.
- Retire Told {1,2,3} with req=3'b111 and count=1:
  - Only lane2 is granted.
  - Next cycle count=3 and entries at old tail hold 1,2,3.
- Allocate 10 PRs, retire 4 (Told 5,6,7,8), assert BPRecoverEN:
  - Next cycle count=32 and head=tail=4.
  - The following req=3'b111 returns the squashed PRs 36,37,38.
- Wrap-around: cycle head past index 31 -> allocation at head=31 returns entries[31], entries[0], entries[1] correctly.

Source files
------------

// File: rtl/free_list_if.sv
// Rename-stage free-list port bundle: 3-lane dispatch allocation and 3-lane retire reclaim.
// Dispatch outputs are combinational from free-list state; retire writes land at the next clock edge.
// The requester must keep popcount(dispatch_req) <= free_num; there is no other backpressure.
interface free_list_if #(
    parameter int PR_W = 6
);
    logic [2:0]           dispatch_req;
    logic [2:0][PR_W-1:0] free_pr_out;
    logic [2:0]           free_pr_valid;
    logic [1:0]           free_num;
    logic [2:0]           retire_en;
    logic [2:0][PR_W-1:0] retire_told;

    modport master (
        output dispatch_req, retire_en, retire_told,
        input  free_pr_out, free_pr_valid, free_num
    );

    modport slave (
        input  dispatch_req, retire_en, retire_told,
        output free_pr_out, free_pr_valid, free_num
    );
endinterface

// File: rtl/free_list.sv
// Circular free-PR buffer for a 3-wide rename stage; FREELIST_DEBUG_EN adds state taps and overflow checks.
// Latency: grants are zero-latency (combinational from head); frees and recovery commit at the clock edge.
// Backpressure: free_num = min(count,3) caps the number of grants; frees beyond FL_SIZE are dropped.
module free_list #(
    parameter int PR_NUM = 64,
    parameter int PR_W   = 6,
    parameter int AR_NUM = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        BPRecoverEN,
    free_list_if.slave  fl
`ifdef FREELIST_DEBUG_EN
    ,
    output logic [PR_W-1:0]                      free_list_disp [PR_NUM-AR_NUM],
    output logic [$clog2(PR_NUM-AR_NUM)-1:0]     head_disp,
    output logic [$clog2(PR_NUM-AR_NUM)-1:0]     tail_disp,
    output logic [$clog2(PR_NUM-AR_NUM+1)-1:0]   count_disp
`endif
);
    localparam int FL_SIZE = PR_NUM - AR_NUM;
    localparam int PTR_W   = $clog2(FL_SIZE);
    localparam int CNT_W   = $clog2(FL_SIZE + 1);

    logic [PR_W-1:0]  entries_q [FL_SIZE];
    logic [PR_W-1:0]  entries_d [FL_SIZE];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [1:0]       rank [3];
    logic [1:0]       granted;
    logic [1:0]       freed;
    logic [CNT_W-1:0] avail;
    logic             push_dropped;

    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] k);
        logic [PTR_W:0] s;
        s = {1'b0, p} + {{(PTR_W-1){1'b0}}, k};
        if (s >= (PTR_W+1)'(FL_SIZE))
            s = s - (PTR_W+1)'(FL_SIZE);
        return s[PTR_W-1:0];
    endfunction

    // Lane 2 is oldest, so it takes the entry at head; younger requesters follow.
    always_comb begin
        rank[2] = 2'd0;
        rank[1] = {1'b0, fl.dispatch_req[2]};
        rank[0] = {1'b0, fl.dispatch_req[2]} + {1'b0, fl.dispatch_req[1]};
        for (int i = 0; i < 3; i++) begin
            fl.free_pr_out[i]   = entries_q[ptr_add(head_q, rank[i])];
            fl.free_pr_valid[i] = fl.dispatch_req[i] && !BPRecoverEN
                                  && (CNT_W'(rank[i]) < count_q);
        end
        granted = {1'b0, fl.free_pr_valid[2]} + {1'b0, fl.free_pr_valid[1]}
                + {1'b0, fl.free_pr_valid[0]};
        fl.free_num = (count_q >= CNT_W'(3)) ? 2'd3 : count_q[1:0];
    end

    // Slots vacated by this cycle's grants may be refilled; only pushes past FL_SIZE are dropped.
    always_comb begin
        entries_d    = entries_q;
        avail        = count_q - CNT_W'(granted);
        freed        = 2'd0;
        push_dropped = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            if (fl.retire_en[i]) begin
                if ((avail + CNT_W'(freed)) < CNT_W'(FL_SIZE)) begin
                    entries_d[ptr_add(tail_q, freed)] = fl.retire_told[i];
                    freed = freed + 2'd1;
                end else begin
                    push_dropped = 1'b1;
                end
            end
        end
        tail_d = ptr_add(tail_q, freed);
        if (BPRecoverEN) begin
            head_d  = tail_d;
            count_d = CNT_W'(FL_SIZE);
        end else begin
            head_d  = ptr_add(head_q, granted);
            count_d = avail + CNT_W'(freed);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FL_SIZE; i++)
                entries_q[i] <= PR_W'(AR_NUM + i);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= CNT_W'(FL_SIZE);
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

`ifdef FREELIST_DEBUG_EN
    assign free_list_disp = entries_q;
    assign head_disp      = head_q;
    assign tail_disp      = tail_q;
    assign count_disp     = count_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!push_dropped)
                else $error("free_list: retire overflow, count=%0d", count_q);
            assert ((popcount3(fl.dispatch_req) <= count_q) || BPRecoverEN)
                else $error("free_list: dispatch requests exceed count=%0d", count_q);
        end
    end

    function automatic logic [CNT_W-1:0] popcount3(input logic [2:0] v);
        return CNT_W'(v[0]) + CNT_W'(v[1]) + CNT_W'(v[2]);
    endfunction
`else
    logic unused_dbg;
    assign unused_dbg = push_dropped;
`endif
endmodule
